// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default instruction width, instruction type and reset polarity.
package pipe_pkg;
    localparam int unsigned IW_DEFAULT = 8;
    typedef logic [IW_DEFAULT-1:0] inst_t;
    localparam logic RST_ACTIVE = 1'b0;
endpackage

// File: rtl/inst_fifo_core.sv
// Storage, pointers and occupancy for the issue buffer; caller qualifies push/pop.
module inst_fifo_core
    import pipe_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IW    = IW_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [IW-1:0]              wr_data,
    output logic [IW-1:0]              rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CNTW = AW + 1;

    logic [IW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CNTW-1:0] count_q;
    logic [CNTW-1:0] count_nxt;
    logic            full_q;
    logic            empty_q;

    // Occupancy next-state; clear wins over any handshake.
    always_comb begin
        count_nxt = count_q;
        if (clr) begin
            count_nxt = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_nxt = count_q + CNTW'(1);
                2'b01:   count_nxt = count_q - CNTW'(1);
                default: count_nxt = count_q;
            endcase
        end
    end

    // Flags are registered from the next count so they stay free of input paths.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= wr_data;
                    wr_ptr      <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
            end
            count_q <= count_nxt;
            full_q  <= (count_nxt == CNTW'(DEPTH));
            empty_q <= (count_nxt == '0);
        end
    end

    assign rd_data = mem[rd_ptr];
    assign count   = count_q;
    assign full    = full_q;
    assign empty   = empty_q;
endmodule

// File: rtl/inst_issue_buffer.sv
// Issue buffer in front of the in-order pipeline: FIFO with flush, handshake gating
// and a wrapping count of issued instructions.
module inst_issue_buffer
    import pipe_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IW    = IW_DEFAULT,
    parameter int unsigned CW    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [IW-1:0]          in_inst,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [IW-1:0]          inst,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic [CW-1:0]          issued
);
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [CW-1:0] issued_q;

    assign in_ready   = !full;
    assign inst_valid = !empty;
    assign push       = in_valid && in_ready && !flush;
    assign pop        = inst_valid && inst_ready && !flush;

    inst_fifo_core #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .clr     (flush),
        .push    (push),
        .pop     (pop),
        .wr_data (in_inst),
        .rd_data (inst),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    // Debug counter of completed issues; survives flush, wraps silently.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            issued_q <= '0;
        end else if (pop) begin
            issued_q <= issued_q + CW'(1);
        end
    end

    assign issued = issued_q;
endmodule

// File: tb/tb_inst_issue_buffer.sv
// Scoreboard bench for inst_issue_buffer: stimulus queues expected issue words,
// a negedge monitor pops and compares them on every issue handshake.
module tb_inst_issue_buffer;
    import pipe_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    inst_t         in_inst = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    inst_t         inst;
    logic          inst_valid;
    logic          inst_ready = 1'b0;
    logic [2:0]    count;
    logic [CW-1:0] issued;

    int            checks = 0;
    int            errors = 0;
    inst_t         exp_q[$];
    int            m_count = 0;
    logic [CW-1:0] m_issued = '0;

    inst_issue_buffer #(
        .DEPTH (DEPTH),
        .IW    (8),
        .CW    (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_inst    (in_inst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .count      (count),
        .issued     (issued)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every issue handshake must match the oldest expected word.
    initial begin
        forever begin : mon
            inst_t e;
            @(negedge clk);
            if (rst && inst_valid && inst_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL issue_unexpected: got %0h expected no issue at %0t", inst, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("issue_data", int'(inst), int'(e));
                end
            end
        end
    end

    task automatic check_state();
        chk("count", int'(count), m_count);
        chk("issued", int'(issued), int'(m_issued));
        chk("in_ready", int'(in_ready), int'(m_count != int'(DEPTH)));
        chk("inst_valid", int'(inst_valid), int'(m_count != 0));
    endtask

    // One clock of stimulus; model decides acceptance/issue from its own occupancy.
    task automatic cycle(input logic iv, input inst_t d, input logic rdy, input logic fl);
        bit acc;
        bit iss;
        in_valid   = iv;
        in_inst    = d;
        inst_ready = rdy;
        flush      = fl;
        acc = iv && (m_count != int'(DEPTH)) && !fl;
        iss = rdy && (m_count != 0) && !fl;
        if (fl) exp_q.delete();
        if (acc) exp_q.push_back(d);
        @(posedge clk);
        #1;
        if (fl) m_count = 0;
        else    m_count = m_count + int'(acc) - int'(iss);
        if (iss) m_issued = m_issued + CW'(1);
        check_state();
    endtask

    task automatic apply_reset();
        rst        = 1'b0;
        in_valid   = 1'b1;
        in_inst    = 8'h77;
        inst_ready = 1'b0;
        flush      = 1'b0;
        exp_q.delete();
        m_count  = 0;
        m_issued = '0;
        repeat (2) @(posedge clk);
        #1;
        check_state();
        rst = 1'b1;
    endtask

    initial begin
        #2;
        apply_reset();

        // Accept right after release, then fill under back-pressure.
        cycle(1'b1, 8'h77, 1'b0, 1'b0);
        chk("first_word", int'(inst), 'h77);
        cycle(1'b1, 8'h64, 1'b0, 1'b0);
        cycle(1'b1, 8'h12, 1'b0, 1'b0);
        cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        chk("head_held", int'(inst), 'h77);
        repeat (4) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Full with simultaneous dequeue: no pass-through, then enqueue+dequeue.
        cycle(1'b1, 8'h21, 1'b0, 1'b0);
        cycle(1'b1, 8'h32, 1'b0, 1'b0);
        cycle(1'b1, 8'h43, 1'b0, 1'b0);
        cycle(1'b1, 8'h54, 1'b0, 1'b0);
        cycle(1'b1, 8'hA1, 1'b1, 1'b0);
        cycle(1'b1, 8'hA1, 1'b1, 1'b0);

        // Flush with both handshakes offered, then a fresh word issues first.
        cycle(1'b1, 8'h99, 1'b1, 1'b1);
        cycle(1'b1, 8'h55, 1'b0, 1'b0);
        chk("post_flush_head", int'(inst), 'h55);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset between edges with two entries queued.
        cycle(1'b1, 8'hE1, 1'b0, 1'b0);
        cycle(1'b1, 8'hE2, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        exp_q.delete();
        m_count  = 0;
        m_issued = '0;
        #1;
        check_state();
        chk("reset_storage", int'(inst), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Stream 17 words at full rate; 4-bit issue counter wraps to 1.
        for (int i = 0; i < 17; i++) begin
            cycle(1'b1, inst_t'(32'h80 + i), 1'b1, 1'b0);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("issued_wrap", int'(issued), 1);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/inst_issue_buffer.md
# inst_issue_buffer

Instruction issue buffer sitting directly upstream of the in-order execution pipeline: it accepts 8-bit instruction words from the fetch source, queues them in a small FIFO, and presents them to the pipeline's `inst`/`inst_valid`/`inst_ready` issue port. It absorbs pipeline back-pressure (EX/WB stalls surface as `inst_ready` low), supports a single-cycle flush on redirect/event, and keeps a wrapping count of issued instructions for waveform/CEX debug.

## Interface
- `DEPTH`, 4, number of queue entries; power of two, ≥ 2
- `IW`, 8, instruction word width
- `CW`, 16, width of the issued-instruction counter
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset; asynchronous, active-low
- `flush`  in  1  discard all queued entries this cycle
- `in_inst`  in  IW  instruction from fetch source
- `in_valid`  in  1  `in_inst` valid
- `in_ready`  out  1  buffer can accept; equals `count != DEPTH`
- `inst`  out  IW  head instruction to pipeline
- `inst_valid`  out  1  head valid; equals `count != 0`
- `inst_ready`  in  1  pipeline accepts head
- `count`  out  $clog2(DEPTH)+1  current occupancy
- `issued`  out  CW  number of completed issue handshakes, wraps modulo 2^CW

## Operation
- Enqueue when `in_valid && in_ready && !flush`: write `in_inst` at write pointer, advance pointer.
- Dequeue when `inst_valid && inst_ready && !flush`: advance read pointer, `issued <= issued + 1`.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance; legal at any non-full, non-empty occupancy.
- Full (`count == DEPTH`): `in_ready` low even if a dequeue occurs this cycle (no full-cycle pass-through).
- Empty: no bypass; `inst_valid` low, `inst` holds last stale storage value (don't-care).
- Pointers are `$clog2(DEPTH)` bits and wrap naturally; `count` is the sole full/empty authority.
- `flush` has priority over everything: count and both pointers cleared, enqueue and dequeue in that cycle suppressed, `issued` not incremented and not cleared.
- `issued` wraps from 2^CW−1 to 0 with no flag.
- Protocol obligations on outputs: while `inst_valid && !inst_ready`, `inst` and `inst_valid` hold stable next cycle (unless `flush`).
- Upstream obligation (asserted in bench, not checked in RTL): `in_inst` stable while `in_valid && !in_ready`.

## Timing
- Reset (asynchronous assert, synchronous release in reset domain): `count=0`, pointers 0, `issued=0`, `inst_valid=0`, `in_ready=1`, storage contents `inst = 0`.
- Reset mid-operation discards all entries immediately; no handshake completes in a cycle where `rst` is low.
- Fill latency: word accepted at edge N is visible on `inst` with `inst_valid=1` after edge N (earliest issue handshake at edge N+1).
- `in_ready`, `inst_valid`, `inst` are pure functions of registered state (no combinational path from `inst_ready` or `in_valid`).
- Throughput: 1 instruction/cycle sustained when `inst_ready` held high and upstream streams.
- After `flush` at edge N: `inst_valid=0`, `in_ready=1` from edge N onward; new word accepted at edge N+1 earliest.

## Structure
- Shared package `pipe_pkg`: `IW` default, `inst_t` (logic [IW-1:0]) typedef, and the reset-polarity constant used by all pipeline blocks.
- One sub-module `inst_fifo_core`: storage array, pointers, count, full/empty; top level adds flush gating, handshake qualification and the `issued` counter.

## Test plan
- Reset: hold `rst=0` 2 cycles with `in_valid=1`, `in_inst=8'h77` -> `count=0`, `inst_valid=0`, `in_ready=1`, `issued=0`; release, word accepted next edge, `inst=8'h77`, `inst_valid=1`.
- Back-pressure: enqueue 8'h77, 8'h64, 8'h12, 8'h3C with `inst_ready=0` -> `count=4`, `in_ready=0`, `inst` held at 8'h77; then `inst_ready=1` 4 cycles -> issue order 77,64,12,3C, `issued=4`, `count=0`.
- Full with simultaneous dequeue: at `count=4`, `in_valid=1`, `inst_ready=1` -> one issue, no enqueue, `count=3`; next cycle enqueue+dequeue -> `count=3`.
- Flush: `count=3`, assert `flush` with `in_valid=1` and `inst_ready=1` -> `count=0`, `issued` unchanged, no word accepted; next 8'h55 issued as first word.
- Wrap: `CW=4`, stream 17 words with `inst_ready=1` -> `issued` reads 1, pointers wrap, data order preserved.
- Async reset mid-stream: drop `rst` between edges with `count=2` -> outputs reach reset values without clock edge.
